// File: rtl/uart_mmio_responder_pkg.sv
// Shared constants for the UART MMIO responder:
// register word offsets and STATUS bit positions.
package uart_mmio_responder_pkg;

  typedef enum logic [13:0] {
    REG_STATUS = 14'd0,
    REG_RXDATA = 14'd1,
    REG_TXDATA = 14'd2,
    REG_LEVELS = 14'd3
  } reg_e;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_OVF       = 2;

  function automatic logic [7:0] lvl8(input logic [15:0] c);
    return c[7:0];
  endfunction

endpackage

// File: rtl/uart_mmio_responder_sync_fifo.sv
// First-word fall-through synchronous FIFO.
// A push into an empty FIFO becomes visible the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// CPU IO-space responder for the UART window with RX/TX FIFOs.
// Loads return one cycle later and reflect the pre-edge state.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] io_addr,
  input  logic        io_re,
  input  logic [3:0]  io_we,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [7:0]       w_rx_head;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [CNT_W-1:0] w_rx_count;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic [CNT_W-1:0] w_tx_count;
  logic             w_tx_wr;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_ovf_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;
  logic             r_tx_ovf;
  logic [31:0]      r_dout;

  assign rx_ready  = ~rst & ~w_rx_full;
  assign w_rx_push = rx_valid & rx_ready;
  assign w_rx_pop  = io_re & (io_addr == REG_RXDATA) & ~w_rx_empty;

  assign tx_valid  = ~w_tx_empty;
  assign w_tx_pop  = tx_valid & tx_ready;
  assign w_tx_wr   = io_we[0] & (io_addr == REG_TXDATA);
  assign w_tx_push = w_tx_wr & ~w_tx_full;
  assign w_ovf_clr = io_we[0] & (io_addr == REG_STATUS) & io_din[ST_TX_OVF];

  assign w_unused  = ^{io_we[3:1], io_din[31:8]};
  assign io_dout   = r_dout;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (rx_data),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (io_din[7:0]),
    .o_dout  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  always_comb begin
    w_rdata = '0;
    case (io_addr)
      REG_STATUS: begin
        w_rdata[ST_TX_NOT_FULL]  = ~w_tx_full;
        w_rdata[ST_RX_NOT_EMPTY] = ~w_rx_empty;
        w_rdata[ST_TX_OVF]       = r_tx_ovf;
      end
      REG_RXDATA: w_rdata = {24'b0, w_rx_empty ? 8'h00 : w_rx_head};
      REG_LEVELS: w_rdata = {8'b0, lvl8(16'(w_rx_count)),
                             8'b0, lvl8(16'(w_tx_count))};
      default:    w_rdata = '0;
    endcase
  end

  // Overflow set takes priority over a same-cycle software clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_tx_wr & w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_ovf_clr)      r_tx_ovf <= 1'b0;
      if (io_re) r_dout <= w_rdata;
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed self-checking bench for uart_mmio_responder.
// Inputs change 1ns after each rising edge; outputs sampled there.
module tb_uart_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] io_addr;
  logic        io_re;
  logic [3:0]  io_we;
  logic [31:0] io_din;
  logic [31:0] io_dout;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  uart_mmio_responder #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [13:0] a);
    io_addr = a;
    io_re   = 1'b1;
    tick();
    io_re   = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    io_addr = a;
    io_din  = d;
    io_we   = 4'h1;
    tick();
    io_we   = 4'h0;
  endtask

  initial begin
    rst = 1'b1; io_addr = '0; io_re = 1'b0; io_we = '0; io_din = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    tick();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    chk("rst_dout", io_dout, 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    #1;

    // 1: status after reset
    rd(14'd0);
    chk("t1_status", io_dout, 32'h0000_0001);
    chk("t1_tx_valid", 32'(tx_valid), 32'd0);
    chk("t1_rx_ready", 32'(rx_ready), 32'd1);

    // 2: RX push and read-out
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    rd(14'd3);
    chk("t2_levels", io_dout, 32'h0002_0000);
    rd(14'd1);
    chk("t2_rx0", io_dout, 32'h41);
    rd(14'd1);
    chk("t2_rx1", io_dout, 32'h42);
    rd(14'd1);
    chk("t2_rx_empty", io_dout, 32'h0);

    // 3: TX overflow and sticky flag
    for (int i = 0; i < 9; i++) wr(14'd2, 32'h10 + 32'(i));
    rd(14'd0);
    chk("t3_status_ovf", io_dout, 32'h0000_0004);
    chk("t3_tx_head", {23'b0, tx_valid, tx_data}, 32'h110);
    rd(14'd3);
    chk("t3_levels", io_dout, 32'h0000_0008);
    io_addr = 14'd0; io_din = 32'h4; io_we = 4'h1; io_re = 1'b1;
    tick();
    io_we = 4'h0; io_re = 1'b0;
    chk("t3_clr_same_rd", io_dout, 32'h0000_0004);
    rd(14'd0);
    chk("t3_status_clr", io_dout, 32'h0000_0000);

    // 4: drain in order
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_drain", {23'b0, tx_valid, tx_data}, 32'h110 + 32'(k));
      tick();
    end
    chk("t4_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // 5: full FIFO, write during pop is dropped
    for (int i = 0; i < 8; i++) wr(14'd2, 32'h20 + 32'(i));
    tx_ready = 1'b1;
    wr(14'd2, 32'h99);
    tx_ready = 1'b0;
    rd(14'd0);
    chk("t5_status", io_dout, 32'h0000_0005);
    rd(14'd3);
    chk("t5_levels", io_dout, 32'h0000_0007);
    chk("t5_tx_head", 32'(tx_data), 32'h21);

    // 6: reset discards buffered bytes
    tx_ready = 1'b1; tick(); tick(); tx_ready = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h60 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    rd(14'd3);
    chk("t6_levels_pre", io_dout, 32'h0003_0005);
    rst = 1'b1;
    #1;
    chk("t6_rst_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("t6_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_dout", io_dout, 32'h0);
    rd(14'd3);
    chk("t6_levels", io_dout, 32'h0);
    rd(14'd0);
    chk("t6_status", io_dout, 32'h0000_0001);

    // 7: simultaneous push/pop, and push into empty
    rx_valid = 1'b1; rx_data = 8'h55; tick();
    rx_data = 8'h66;
    rd(14'd1);
    rx_valid = 1'b0;
    chk("t7_pushpop_rd", io_dout, 32'h55);
    rd(14'd3);
    chk("t7_levels", io_dout, 32'h0001_0000);
    rd(14'd1);
    chk("t7_rx_next", io_dout, 32'h66);
    rx_valid = 1'b1; rx_data = 8'h77;
    rd(14'd1);
    rx_valid = 1'b0;
    chk("t7_empty_push_rd", io_dout, 32'h0);
    rd(14'd1);
    chk("t7_rx_late", io_dout, 32'h77);
    rd(14'd7);
    chk("t7_unmapped", io_dout, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
